// File: rtl/fetch_sequencer_pkg.sv
// Definitions shared by the fetch sequencer and the fetch unit: default widths and the
// encoding of the sequencer states.
package fetch_sequencer_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_CNT_W  = 16;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } seqState_t;

endpackage

// File: rtl/fetch_sequencer_redirect_arbiter.sv
// Picks the redirect to apply this cycle. The EX branch is the older instruction, so it
// beats the ID jump. A jump seen during a load-use stall is ignored because the hazard
// unit presents it again once the stall clears.
module redirect_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              branchTaken,
    input  logic [ADDR_W-1:0] branchTarget,
    input  logic              jumpValid,
    input  logic [ADDR_W-1:0] jumpTarget,
    input  logic              stallReq,
    output logic              redirectValid,
    output logic [ADDR_W-1:0] redirectTarget
);

    always_comb begin
        redirectValid  = 1'b0;
        redirectTarget = '0;
        if (branchTaken) begin
            redirectValid  = 1'b1;
            redirectTarget = branchTarget;
        end else if (jumpValid && !stallReq) begin
            redirectValid  = 1'b1;
            redirectTarget = jumpTarget;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch control. Drives the fetch unit's PC enable and redirect mux, parks a redirect
// while instruction memory is busy, and generates the IF/ID enable and flush controls.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Branch_Taken,
    input  logic [ADDR_W-1:0] Branch_Target,
    input  logic              Jump_Valid,
    input  logic [ADDR_W-1:0] Jump_Target,
    input  logic              Stall_Req,
    input  logic              Imem_Ready,
    input  logic              Halt_Req,
    output logic              PCWrite,
    output logic              Jump,
    output logic [ADDR_W-1:0] NewPC,
    output logic              IFID_Write,
    output logic              IFID_Flush,
    output logic              Halted,
    output logic [CNT_W-1:0]  Redirect_Count
);

    localparam bit         USE_FLUSH  = (FLUSH_CYCLES > 1);
    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

    seqState_t         state;
    seqState_t         nextState;
    logic              pendValid;
    logic [ADDR_W-1:0] pendTarget;
    logic [1:0]        flushLeft;
    logic [CNT_W-1:0]  redirectCount;

    logic              arbValid;
    logic [ADDR_W-1:0] arbTarget;
    logic              effValid;
    logic [ADDR_W-1:0] effTarget;
    logic              applyRedirect;
    logic              capturePend;

    redirect_arbiter #(.ADDR_W(ADDR_W)) u_arbiter (
        .branchTaken   (Branch_Taken),
        .branchTarget  (Branch_Target),
        .jumpValid     (Jump_Valid),
        .jumpTarget    (Jump_Target),
        .stallReq      (Stall_Req),
        .redirectValid (arbValid),
        .redirectTarget(arbTarget)
    );

    // A redirect arriving this cycle is younger than the parked one, so it replaces it.
    assign effValid  = arbValid | pendValid;
    assign effTarget = arbValid ? arbTarget : pendTarget;

    always_comb begin
        nextState     = state;
        PCWrite       = 1'b0;
        Jump          = 1'b0;
        NewPC         = '0;
        IFID_Write    = 1'b0;
        IFID_Flush    = 1'b0;
        applyRedirect = 1'b0;
        capturePend   = 1'b0;
        if (!Reset) begin
            IFID_Flush = 1'b1;
            nextState  = RUN;
        end else if (state == HALT) begin
            IFID_Flush = 1'b1;
        end else if (effValid) begin
            IFID_Flush = 1'b1;
            if (Imem_Ready) begin
                PCWrite       = 1'b1;
                Jump          = 1'b1;
                NewPC         = effTarget;
                IFID_Write    = 1'b1;
                applyRedirect = 1'b1;
                nextState     = USE_FLUSH ? FLUSH : RUN;
            end else begin
                capturePend = 1'b1;
                nextState   = WAIT;
            end
        end else if (state == FLUSH) begin
            PCWrite    = Imem_Ready;
            IFID_Write = Imem_Ready;
            IFID_Flush = 1'b1;
            if (flushLeft <= 2'd1) begin
                nextState = RUN;
            end
        end else if (!Imem_Ready) begin
            IFID_Flush = 1'b1;
            nextState  = WAIT;
        end else if (Stall_Req) begin
            nextState = RUN;
        end else if (Halt_Req) begin
            IFID_Flush = 1'b1;
            nextState  = HALT;
        end else begin
            PCWrite    = 1'b1;
            IFID_Write = 1'b1;
            nextState  = RUN;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state         <= RUN;
            pendValid     <= 1'b0;
            pendTarget    <= '0;
            flushLeft     <= 2'd0;
            redirectCount <= '0;
        end else begin
            state <= nextState;
            if (applyRedirect) begin
                pendValid <= 1'b0;
            end else if (capturePend) begin
                pendValid  <= 1'b1;
                pendTarget <= effTarget;
            end
            if (applyRedirect) begin
                flushLeft <= FLUSH_LOAD;
            end else if (state == FLUSH && flushLeft != 2'd0) begin
                flushLeft <= flushLeft - 2'd1;
            end
            // The counter sticks at all-ones instead of wrapping.
            if (applyRedirect && redirectCount != '1) begin
                redirectCount <= redirectCount + CNT_W'(1);
            end
        end
    end

    assign Halted         = (state == HALT);
    assign Redirect_Count = redirectCount;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Controls the instruction fetch unit: drives its PC write-enable, its jump-select input and its new-PC value every cycle.
Arbitrates between two redirect sources: a taken branch resolved in EX and a jump decoded in ID. Also arbitrates load-use stalls, instruction-memory wait states and program halt.
Buffers a redirect that arrives while instruction memory is busy, and generates IF/ID flush and write-enable controls.
Sits between the hazard/branch logic and the fetch unit; the PC register itself stays in the fetch unit.

Parameters:
ADDR_W, 32, width of PC and redirect targets
FLUSH_CYCLES, 1, cycles IFID_Flush stays high per redirect (1..4)
CNT_W, 16, width of the redirect performance counter

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset (0 = reset)
Branch_Taken  input  1  EX-stage branch resolved taken this cycle
Branch_Target  input  ADDR_W  branch destination
Jump_Valid  input  1  ID-stage jump/jr decoded this cycle
Jump_Target  input  ADDR_W  jump destination
Stall_Req  input  1  load-use stall request from hazard unit
Imem_Ready  input  1  instruction memory data valid this cycle
Halt_Req  input  1  halt instruction in ID
PCWrite  output  1  PC update enable to fetch unit
Jump  output  1  select NewPC instead of PC+4
NewPC  output  ADDR_W  redirect address to fetch unit
IFID_Write  output  1  IF/ID pipeline register enable
IFID_Flush  output  1  zero the IF/ID register (bubble)
Halted  output  1  fetch permanently stopped
Redirect_Count  output  CNT_W  number of applied redirects

Behaviour:
- States: RUN, WAIT, FLUSH, HALT. Reset state is RUN.
- While Reset=0: PCWrite=0, Jump=0, NewPC=0, IFID_Write=0, IFID_Flush=1, Halted=0, Redirect_Count=0, pending register cleared. Reset asserted mid-operation discards any pending redirect immediately.
- Outputs PCWrite, Jump, NewPC, IFID_Write and IFID_Flush are combinational from state and inputs, so a redirect reaches the PC on the same edge. Latency is 0 cycles.
- Redirect priority, highest first:
  - Branch_Taken (older instruction).
  - Jump_Valid.
  - Branch and jump in the same cycle: branch wins, jump dropped.
  - Jump_Valid is ignored while Stall_Req=1; the hazard unit re-presents it.
- RUN:
  - Redirect and Imem_Ready=1: Jump=1, NewPC=target, PCWrite=1, IFID_Write=1, IFID_Flush=1. Counter +1. Go to FLUSH if FLUSH_CYCLES>1, else stay RUN.
  - Redirect and Imem_Ready=0: latch target into pending, PCWrite=0, IFID_Write=0, IFID_Flush=1. Go to WAIT.
  - No redirect, Imem_Ready=0: PCWrite=0, IFID_Write=0, IFID_Flush=1 (bubble). Go to WAIT.
  - No redirect, Stall_Req=1: PCWrite=0, IFID_Write=0, IFID_Flush=0. A taken branch overrides the stall.
  - Halt_Req=1 with no branch: PCWrite=0, IFID_Flush=1. Go to HALT. A branch in the same cycle wins and Halt_Req is ignored.
  - Otherwise: PCWrite=1, Jump=0, IFID_Write=1, IFID_Flush=0.
- WAIT:
  - PCWrite=0, IFID_Write=0, IFID_Flush=1 while Imem_Ready=0.
  - A new branch arriving in WAIT overwrites pending; a later branch always wins.
  - On Imem_Ready=1: if pending is valid, apply it (Jump=1, NewPC=pending, PCWrite=1, counter +1, clear pending). Otherwise resume with RUN semantics for that cycle. Then go to FLUSH or RUN as from RUN.
- FLUSH:
  - IFID_Flush=1 for FLUSH_CYCLES-1 cycles, counted by a down-counter. Fetch proceeds (PCWrite=Imem_Ready).
  - A new branch in FLUSH is applied and restarts the count.
  - Return to RUN when the count reaches 0.
- HALT: PCWrite=0, IFID_Write=0, IFID_Flush=1, Halted=1. Stays here until Reset.
- Redirect_Count saturates at all-ones; it does not wrap.
- NewPC=0 whenever Jump=0.

Decomposition:
- Shared package: state encoding constants (RUN=2'd0, WAIT=2'd1, FLUSH=2'd2, HALT=2'd3), and ADDR_W and CNT_W defaults shared with the fetch unit.
- One sub-module: redirect_arbiter. It is combinational priority selection of branch vs jump, producing a valid bit and a target.
- State register, pending register, flush counter and perf counter stay in fetch_sequencer.

Test Plan:
- Reset low, then high with Imem_Ready=1 and no requests -> PCWrite=1, Jump=0, IFID_Write=1, IFID_Flush=0 every cycle; counter 0.
- Branch_Taken=1, Branch_Target=0x40 with Jump_Valid=1, Jump_Target=0x80 in the same cycle -> Jump=1, NewPC=0x40, IFID_Flush=1, counter=1.
- Imem_Ready=0 for 3 cycles, Branch_Target=0x100 in cycle 1 and 0x200 in cycle 2 -> PCWrite=0 during wait; on ready NewPC=0x200, Jump=1; counter +1 only.
- Stall_Req=1 for 2 cycles with Jump_Valid=1 -> PCWrite=0, IFID_Write=0, Jump=0. Then Branch_Taken during the stall -> redirect applied immediately.
- FLUSH_CYCLES=3, one branch -> IFID_Flush high exactly 3 consecutive cycles, fetch continuing.
- Halt_Req=1 -> Halted=1, PCWrite=0 forever. Then Reset pulse low mid-HALT -> all outputs return to reset values and RUN resumes.
